// File: rtl/dmni_mem_arbiter_pkg.sv
// Shared types for the DMNI memory-port arbiter.
// One muxed memory request bundle and the port read latency.
package dmni_mem_arbiter_pkg;

   localparam int unsigned MEM_LATENCY = 1;
   localparam int unsigned MEM_ADDR_W  = 32;

   typedef struct packed {
      logic [3:0]            we;
      logic [MEM_ADDR_W-1:0] addr;
      logic [31:0]           wdata;
   } mem_req_t;

endpackage

// File: rtl/dmni_mem_arbiter_rr_picker.sv
// Combinational round-robin picker.
// Returns a one-hot grant for the first asserted request at or after start.
module dmni_rr_picker
   import dmni_mem_arbiter_pkg::*;
#(
   parameter int unsigned N_REQ = 3,
   localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IDX_W-1:0] start,
   output logic [N_REQ-1:0] gnt
);

   logic found;

   always_comb begin
      gnt   = '0;
      found = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
         for (int j = 0; j < N_REQ; j++) begin
            if (!found && req[j] && (j == (int'(start) + i) % N_REQ)) begin
               gnt[j] = 1'b1;
               found  = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/dmni_mem_arbiter.sv
// DMNI memory-port arbiter: round-robin with bounded locked bursts.
// One access per cycle; read data returns tagged one cycle after the grant.
module dmni_mem_arbiter
   import dmni_mem_arbiter_pkg::*;
#(
   parameter int unsigned N_REQ     = 3,
   parameter int unsigned MAX_BURST = 16,
   parameter int unsigned ADDR_W    = 32
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic [N_REQ-1:0]             req_i,
   input  logic [N_REQ-1:0]             lock_i,
   input  logic [N_REQ-1:0][3:0]        we_i,
   input  logic [N_REQ-1:0][ADDR_W-1:0] addr_i,
   input  logic [N_REQ-1:0][31:0]       wdata_i,
   output logic [N_REQ-1:0]             gnt_o,
   output logic [N_REQ-1:0]             rvalid_o,
   output logic [31:0]                  rdata_o,
   output logic                         mem_en_o,
   output logic [3:0]                   mem_we_o,
   output logic [ADDR_W-1:0]            mem_addr_o,
   input  logic [31:0]                  mem_data_i,
   output logic [31:0]                  mem_data_o
);

   localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int unsigned BW    = $clog2(MAX_BURST + 1);

   logic             owner_vld_q;
   logic [IDX_W-1:0] owner_q;
   logic [IDX_W-1:0] rr_ptr_q;
   logic [BW-1:0]    burst_q;

   logic             owner_hit;
   logic             burst_ok;
   logic [IDX_W-1:0] start;
   logic [N_REQ-1:0] rr_gnt;
   logic [N_REQ-1:0] owner_oh;
   logic [N_REQ-1:0] rd_gnt;
   logic [IDX_W-1:0] gidx;
   mem_req_t         sel;

   function automatic logic [IDX_W-1:0] nxt(input logic [IDX_W-1:0] x);
      return (x == IDX_W'(N_REQ - 1)) ? '0 : x + IDX_W'(1);
   endfunction

   assign burst_ok  = burst_q < BW'(MAX_BURST);
   assign owner_hit = owner_vld_q && req_i[owner_q] && burst_ok;
   assign start     = owner_vld_q ? nxt(owner_q) : rr_ptr_q;

   dmni_rr_picker #(.N_REQ(N_REQ)) u_picker (
      .req   (req_i),
      .start (start),
      .gnt   (rr_gnt)
   );

   always_comb begin
      owner_oh = '0;
      rd_gnt   = '0;
      gidx     = '0;
      for (int k = 0; k < N_REQ; k++) begin
         owner_oh[k] = (owner_q == IDX_W'(k));
      end
      if (rst_i)
         gnt_o = '0;
      else if (owner_hit)
         gnt_o = owner_oh;
      else
         gnt_o = rr_gnt;
      for (int k = 0; k < N_REQ; k++) begin
         if (gnt_o[k]) gidx = IDX_W'(k);
         rd_gnt[k] = gnt_o[k] && (we_i[k] == 4'h0);
      end
   end

   // Idle port presents index 0; only the write enables are forced low.
   always_comb begin
      sel.we     = we_i[gidx];
      sel.addr   = MEM_ADDR_W'(addr_i[gidx]);
      sel.wdata  = wdata_i[gidx];
      mem_en_o   = |gnt_o;
      mem_we_o   = mem_en_o ? sel.we : 4'h0;
      mem_addr_o = sel.addr[ADDR_W-1:0];
      mem_data_o = sel.wdata;
   end

   assign rdata_o = mem_data_i;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         owner_vld_q <= 1'b0;
         owner_q     <= '0;
         rr_ptr_q    <= '0;
         burst_q     <= '0;
         rvalid_o    <= '0;
      end else begin
         rvalid_o <= rd_gnt;
         if (|gnt_o) begin
            rr_ptr_q <= nxt(gidx);
            if (lock_i[gidx]) begin
               owner_vld_q <= 1'b1;
               owner_q     <= gidx;
               // A forced re-grant to the same owner restarts the burst.
               if (owner_vld_q && (owner_q == gidx) && burst_ok)
                  burst_q <= burst_q + BW'(1);
               else
                  burst_q <= BW'(1);
            end else begin
               owner_vld_q <= 1'b0;
               burst_q     <= '0;
            end
         end else begin
            owner_vld_q <= 1'b0;
            burst_q     <= '0;
         end
      end
   end

endmodule

// File: tb/tb_dmni_mem_arbiter.sv
// Self-checking bench for dmni_mem_arbiter (N_REQ=3, MAX_BURST=4).
// Directed vectors plus a per-cycle arbitration model.
module tb_dmni_mem_arbiter;

   localparam int N    = 3;
   localparam int MAXB = 4;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [N-1:0]      req = '1;
   logic [N-1:0]      lock = '0;
   logic [N-1:0][3:0] we = '0;
   logic [N-1:0][31:0] addr = '0;
   logic [N-1:0][31:0] wdata = '0;
   logic [N-1:0]      gnt_o;
   logic [N-1:0]      rvalid_o;
   logic [31:0]       rdata_o;
   logic              mem_en_o;
   logic [3:0]        mem_we_o;
   logic [31:0]       mem_addr_o;
   logic [31:0]       mem_data_i = '0;
   logic [31:0]       mem_data_o;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   dmni_mem_arbiter #(.N_REQ(N), .MAX_BURST(MAXB), .ADDR_W(32)) dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .req_i      (req),
      .lock_i     (lock),
      .we_i       (we),
      .addr_i     (addr),
      .wdata_i    (wdata),
      .gnt_o      (gnt_o),
      .rvalid_o   (rvalid_o),
      .rdata_o    (rdata_o),
      .mem_en_o   (mem_en_o),
      .mem_we_o   (mem_we_o),
      .mem_addr_o (mem_addr_o),
      .mem_data_i (mem_data_i),
      .mem_data_o (mem_data_o)
   );

   function automatic logic [31:0] rd_fn(input logic [31:0] a);
      return (a == 32'h100) ? 32'hCAFEF00D : (a ^ 32'hA5A5_0000);
   endfunction

   // Synchronous memory with one cycle of read latency.
   always @(posedge clk)
      mem_data_i <= (mem_en_o && mem_we_o == 4'h0) ? rd_fn(mem_addr_o) : 32'h0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model state: lock owner, burst length, next round-robin start.
   int m_vld = 0, m_own = 0, m_cnt = 0, m_ptr = 0;
   logic [N-1:0] m_rv = '0;
   logic [31:0]  m_rd = '0;

   always @(negedge clk) begin
      logic [N-1:0] e;
      int st, c, gi;
      e  = '0;
      gi = 0;
      if (!rst) begin
         if (m_vld != 0 && req[m_own] && m_cnt < MAXB) begin
            e[m_own] = 1'b1;
         end else begin
            st = (m_vld != 0) ? (m_own + 1) % N : m_ptr;
            for (int i = 0; i < N; i++) begin
               c = (st + i) % N;
               if (e == '0 && req[c]) e[c] = 1'b1;
            end
         end
      end
      for (int i = 0; i < N; i++) if (e[i]) gi = i;
      chk("gnt", 64'(gnt_o), 64'(e));
      chk("mem_en", 64'(mem_en_o), 64'(|e));
      chk("rvalid", 64'(rvalid_o), 64'(m_rv));
      if (m_rv != '0) chk("rdata", 64'(rdata_o), 64'(m_rd));
      if (e != '0) begin
         chk("mem_we", 64'(mem_we_o), 64'(we[gi]));
         chk("mem_addr", 64'(mem_addr_o), 64'(addr[gi]));
         chk("mem_wdata", 64'(mem_data_o), 64'(wdata[gi]));
      end else begin
         chk("mem_we_idle", 64'(mem_we_o), 64'h0);
      end
      if (rst) begin
         m_vld = 0; m_own = 0; m_cnt = 0; m_ptr = 0; m_rv = '0;
      end else begin
         m_rv = '0;
         if (e != '0) begin
            if (we[gi] == 4'h0) begin
               m_rv[gi] = 1'b1;
               m_rd = rd_fn(addr[gi]);
            end
            m_ptr = (gi + 1) % N;
            if (lock[gi]) begin
               m_cnt = (m_vld != 0 && m_own == gi && m_cnt < MAXB) ? m_cnt + 1 : 1;
               m_vld = 1;
               m_own = gi;
            end else begin
               m_vld = 0; m_cnt = 0;
            end
         end else begin
            m_vld = 0; m_cnt = 0;
         end
      end
   end

   task automatic cyc(input logic rs, input logic [N-1:0] r, input logic [N-1:0] l);
      @(posedge clk);
      #1;
      rst  = rs;
      req  = r;
      lock = l;
      @(negedge clk);
   endtask

   initial begin
      logic [N-1:0] exp2 [6];
      logic [N-1:0] exp4 [6];
      exp2 = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
      exp4 = '{3'b010, 3'b010, 3'b010, 3'b010, 3'b100, 3'b010};
      for (int i = 0; i < N; i++) addr[i] = 32'h1000 * (i + 1);

      for (int i = 0; i < 3; i++) begin
         cyc(1'b1, 3'b111, 3'b000);
         chk("t1_gnt", 64'(gnt_o), 64'h0);
         chk("t1_en", 64'(mem_en_o), 64'h0);
         chk("t1_rvalid", 64'(rvalid_o), 64'h0);
      end

      for (int i = 0; i < 6; i++) begin
         cyc(1'b0, 3'b111, 3'b000);
         chk("t2_rr", 64'(gnt_o), 64'(exp2[i]));
      end

      addr[0] = 32'h100;
      cyc(1'b0, 3'b001, 3'b000);
      chk("t3_gnt", 64'(gnt_o), 64'h1);
      cyc(1'b0, 3'b000, 3'b000);
      chk("t3_rvalid", 64'(rvalid_o), 64'h1);
      chk("t3_rdata", 64'(rdata_o), 64'hCAFEF00D);

      for (int i = 0; i < 6; i++) begin
         cyc(1'b0, (i < 5) ? 3'b110 : 3'b010, 3'b010);
         chk("t4_burst", 64'(gnt_o), 64'(exp4[i]));
      end
      cyc(1'b0, 3'b000, 3'b000);

      we[0]    = 4'hF;
      wdata[0] = 32'h12345678;
      addr[0]  = 32'h200;
      cyc(1'b0, 3'b001, 3'b000);
      chk("t5_en", 64'(mem_en_o), 64'h1);
      chk("t5_we", 64'(mem_we_o), 64'hF);
      chk("t5_wdata", 64'(mem_data_o), 64'h12345678);
      cyc(1'b0, 3'b000, 3'b000);
      chk("t5_rvalid", 64'(rvalid_o), 64'h0);
      we[0] = 4'h0;

      for (int i = 0; i < 3; i++) begin
         cyc(1'b0, 3'b100, 3'b100);
         chk("t6_own2", 64'(gnt_o), 64'h4);
      end
      cyc(1'b1, 3'b111, 3'b100);
      chk("t6_rst_gnt", 64'(gnt_o), 64'h0);
      cyc(1'b0, 3'b111, 3'b000);
      chk("t6_after_rst", 64'(gnt_o), 64'h1);

      for (int i = 0; i < 6; i++) begin
         cyc(1'b0, 3'b001, 3'b001);
         chk("t7_solo", 64'(gnt_o), 64'h1);
      end
      cyc(1'b0, 3'b000, 3'b000);
      cyc(1'b0, 3'b000, 3'b000);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
